// File: rtl/ifid_fetch_buf.sv
// Two-entry fetch buffer doubling as the IF/ID register.
// Pairs each ROM address with its next-cycle data and owns fetch back-pressure.
module ifid_fetch_buf #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] inst_rdata,
  input  logic        flush,
  input  logic        id_stall,
  output logic        fetch_stall,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  localparam logic [2:0] FULL = 3'(DEPTH);

  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] buf_pc_q [2];
  logic [31:0] buf_pc_d [2];
  logic [31:0] buf_inst_q [2];
  logic [31:0] buf_inst_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;

  logic        push;
  logic        pop;
  logic [2:0]  fill;

  assign id_valid = ~cpu_rst & (count_q != 2'd0);
  assign id_pc    = id_valid ? buf_pc_q[rd_ptr_q] : 32'h0;
  assign id_inst  = id_valid ? buf_inst_q[rd_ptr_q] : NOP_INST;

  assign pop  = id_valid & ~id_stall & ~flush;
  assign push = pend_v_q & ~flush;

  // Occupancy next cycle if the pending response lands; stall when full.
  assign fill = {1'b0, count_q} + {2'b00, pend_v_q} - {2'b00, pop};
  assign fetch_stall = ~cpu_rst & ~flush & (fill >= FULL);

  always_comb begin
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q + {1'b0, push} - {1'b0, pop};
    pend_pc_d  = fetch_pc;
    pend_v_d   = fetch_req & ~fetch_stall;
    if (push) begin
      buf_pc_d[wr_ptr_q]   = pend_pc_q;
      buf_inst_d[wr_ptr_q] = inst_rdata;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    // A request in the flush cycle is the redirect target.
    if (flush) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      pend_v_d = fetch_req;
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      pend_v_q  <= 1'b0;
      pend_pc_q <= 32'h0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_pc_q[i]   <= 32'h0;
        buf_inst_q[i] <= 32'h0;
      end
    end else begin
      pend_v_q   <= pend_v_d;
      pend_pc_q  <= pend_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
    end
  end

endmodule

// File: tb/tb_ifid_fetch_buf.sv
// Directed bench for ifid_fetch_buf.
// ROM model returns {16'h2400+k, k} with k = pc/4 + 1.
module tb_ifid_fetch_buf;

  logic        clk;
  logic        cpu_rst;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic [31:0] inst_rdata;
  logic        flush;
  logic        id_stall;
  logic        fetch_stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int errs;
  int checks;
  logic [31:0] last_pc;

  ifid_fetch_buf dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (cpu_rst),
    .fetch_req   (fetch_req),
    .fetch_pc    (fetch_pc),
    .inst_rdata  (inst_rdata),
    .flush       (flush),
    .id_stall    (id_stall),
    .fetch_stall (fetch_stall),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_inst     (id_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] pc);
    logic [15:0] k;
    k = pc[17:2] + 16'd1;
    return {16'h2400 + k, k};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; ROM answers the address seen at the edge.
  task automatic tick();
    last_pc = fetch_pc;
    @(posedge clk);
    #1;
    inst_rdata = rom(last_pc);
  endtask

  task automatic drive(input logic rq, input logic [31:0] pc,
                       input logic fl, input logic st);
    fetch_req = rq;
    fetch_pc  = pc;
    flush     = fl;
    id_stall  = st;
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc,
                          input logic [31:0] inst);
    chk({tag, ".v"}, 32'(id_valid), 32'd1);
    chk({tag, ".pc"}, id_pc, pc);
    chk({tag, ".inst"}, id_inst, inst);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".v"}, 32'(id_valid), 32'd0);
    chk({tag, ".inst"}, id_inst, 32'h0);
    chk({tag, ".pc"}, id_pc, 32'h0);
  endtask

  logic [31:0] wrap_inst [5];

  initial begin
    errs       = 0;
    checks     = 0;
    cpu_rst    = 1'b1;
    fetch_req  = 1'b1;
    fetch_pc   = 32'h0;
    inst_rdata = 32'h0;
    flush      = 1'b0;
    id_stall   = 1'b0;
    wrap_inst[0] = 32'h2481_0081;
    wrap_inst[1] = 32'h2482_0082;
    wrap_inst[2] = 32'h2483_0083;
    wrap_inst[3] = 32'h2484_0084;
    wrap_inst[4] = 32'h2485_0085;

    // reset, request held high and ignored
    tick(); drive(1, 32'h0, 0, 0);
    chk_empty("rst0");
    chk("rst0.stall", 32'(fetch_stall), 0);
    tick(); drive(1, 32'h0, 0, 0);
    chk_empty("rst1");
    tick(); cpu_rst = 1'b0; drive(0, 32'h0, 0, 0);
    chk_empty("post_rst");

    // straight stream 0x0, 0x4, 0x8
    tick(); drive(1, 32'h0, 0, 0);
    chk_empty("a0");
    chk("a0.stall", 32'(fetch_stall), 0);
    tick(); drive(1, 32'h4, 0, 0);
    chk_empty("a1");
    chk("a1.stall", 32'(fetch_stall), 0);
    tick(); drive(1, 32'h8, 0, 0);
    chk_head("a2", 32'h0, 32'h2401_0001);
    chk("a2.stall", 32'(fetch_stall), 0);
    tick(); drive(0, 32'h0, 0, 0);
    chk_head("a3", 32'h4, 32'h2402_0002);
    chk("a3.stall", 32'(fetch_stall), 0);
    tick(); drive(0, 32'h0, 0, 0);
    chk_head("a4", 32'h8, 32'h2403_0003);
    tick(); drive(0, 32'h0, 0, 0);
    chk_empty("a5");

    // ID stall fills the buffer; requests under stall are dropped
    tick(); drive(1, 32'h10, 0, 0);
    tick(); drive(1, 32'h14, 0, 0);
    chk("b1.stall", 32'(fetch_stall), 0);
    tick(); drive(1, 32'h18, 0, 1);
    chk_head("b2", 32'h10, 32'h2405_0005);
    chk("b2.stall", 32'(fetch_stall), 1);
    tick(); drive(1, 32'h1c, 0, 1);
    chk_head("b3", 32'h10, 32'h2405_0005);
    chk("b3.stall", 32'(fetch_stall), 1);
    tick(); drive(1, 32'h20, 0, 1);
    chk_head("b4", 32'h10, 32'h2405_0005);
    chk("b4.stall", 32'(fetch_stall), 1);
    tick(); drive(0, 32'h0, 0, 0);
    chk_head("b5", 32'h10, 32'h2405_0005);
    chk("b5.stall", 32'(fetch_stall), 0);
    tick(); drive(0, 32'h0, 0, 0);
    chk_head("b6", 32'h14, 32'h2406_0006);
    tick(); drive(0, 32'h0, 0, 0);
    chk_empty("b7");
    tick(); drive(0, 32'h0, 0, 0);
    chk_empty("b8");

    // flush with an entry held and a response in flight
    tick(); drive(1, 32'h40, 0, 1);
    tick(); drive(1, 32'h44, 0, 1);
    tick(); drive(1, 32'h100, 1, 1);
    chk("c2.stall", 32'(fetch_stall), 0);
    tick(); drive(0, 32'h0, 0, 0);
    chk_empty("c3");
    tick(); drive(0, 32'h0, 0, 0);
    chk_head("c4", 32'h100, 32'h2441_0041);
    tick(); drive(0, 32'h0, 0, 0);
    chk_empty("c5");

    // back-to-back push/pop across pointer wrap
    for (int i = 0; i < 7; i++) begin
      tick();
      drive(i < 5, 32'h200 + 32'(4 * i), 0, 0);
      chk("d.stall", 32'(fetch_stall), 0);
      if (i >= 2)
        chk_head("d", 32'h200 + 32'(4 * (i - 2)), wrap_inst[i-2]);
    end
    tick(); drive(0, 32'h0, 0, 0);
    chk_empty("d_end");

    // reset with the buffer full
    tick(); drive(1, 32'h300, 0, 1);
    tick(); drive(1, 32'h304, 0, 1);
    tick(); drive(0, 32'h0, 0, 1);
    chk("e2.stall", 32'(fetch_stall), 1);
    tick(); drive(0, 32'h0, 0, 1);
    chk_head("e3", 32'h300, 32'h24c1_00c1);
    chk("e3.stall", 32'(fetch_stall), 1);
    tick(); cpu_rst = 1'b1; drive(1, 32'h3fc, 0, 1);
    chk_empty("e4");
    chk("e4.stall", 32'(fetch_stall), 0);
    tick(); cpu_rst = 1'b0; drive(0, 32'h0, 0, 0);
    chk_empty("e5");
    chk("e5.stall", 32'(fetch_stall), 0);
    tick(); drive(0, 32'h0, 0, 0);
    chk_empty("e6");
    tick(); drive(1, 32'h308, 0, 0);
    chk_empty("e7");
    tick(); drive(0, 32'h0, 0, 0);
    chk_empty("e8");
    tick(); drive(0, 32'h0, 0, 0);
    chk_head("e9", 32'h308, 32'h24c3_00c3);
    tick(); drive(0, 32'h0, 0, 0);
    chk_empty("e10");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
